fifo_burst_writer: RTL and testbench
====================================

# fifo_burst_writer

Write-clock-domain producer for the team's asynchronous FIFO write port. It accepts an upstream valid/ready word stream and collects up to BURST_LEN words in a local staging buffer. It pushes each staged group into the FIFO only when the FIFO reports room for the whole group, so that every group lands back-to-back and is never split by full. It sits between the write-side datapath and the async FIFO's wr_en/din/full/wr_count/wr_ack pins.

## Interface
- DATA_WIDTH, 8, word width; matches the FIFO data width.
- FIFO_DEPTH, 16, depth of the attached FIFO.
- BURST_LEN, 4, maximum words per burst; must satisfy 1 ≤ BURST_LEN ≤ FIFO_DEPTH.
- FLUSH_TIMEOUT, 15, idle cycles before a partial burst is flushed; 0 disables the timeout.
- CW (local), $clog2(FIFO_DEPTH-1)+1, FIFO count width.

Ports:
- wr_clk  in  1  write clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  upstream word accepted when s_valid & s_ready.
- s_data  in  DATA_WIDTH  upstream word.
- s_last  in  1  marks the last word of a packet; forces a flush.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_din  out  DATA_WIDTH  FIFO write data.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_count  in  CW  FIFO write-side occupancy. It is pessimistic and never under-reports.
- fifo_wr_ack  in  1  FIFO write acknowledge, arriving one cycle after an accepted write.
- burst_active  out  1  high while a burst is being written.
- bursts_done  out  16  count of completed bursts; wraps modulo 2^16.
- err_overflow  out  1  sticky; set if fifo_full is seen during DRAIN.
- err_ack  out  1  sticky; set on a missing or unexpected fifo_wr_ack.

## Operation
- **States:** IDLE, FILL, WAIT_ROOM, DRAIN.
- **s_ready:** combinational. s_ready = (IDLE|FILL) & stage_cnt < BURST_LEN & !last_seen.
- **IDLE:** an accept writes stage[0], sets stage_cnt=1 and goes to FILL. If s_last is accepted, go directly to WAIT_ROOM.
- **FILL:** each accept appends a word and increments stage_cnt.
  - Go to WAIT_ROOM when stage_cnt reaches BURST_LEN, when s_last is accepted, or when idle_cnt reaches FLUSH_TIMEOUT.
  - idle_cnt counts consecutive cycles with no accept and is cleared on every accept.
- **WAIT_ROOM:** go to DRAIN when (FIFO_DEPTH − fifo_wr_count) ≥ stage_cnt and !fifo_full. Compute the room in CW+1 bits, unsigned.
- **DRAIN:** write stage[0..stage_cnt−1] in order, one word per cycle, with fifo_wr_en continuously high.
  - After the last word, increment bursts_done, clear stage_cnt and last_seen, and go to IDLE.
  - If fifo_full is high in a DRAIN cycle: set err_overflow, deassert fifo_wr_en for that cycle, hold the word index, and resume when full drops.
- **Bypass:** no data bypasses the staging buffer. Word order is preserved exactly.
- **Reset values:** state=IDLE, stage_cnt=0, idle_cnt=0, fifo_wr_en=0, fifo_din=0, burst_active=0, bursts_done=0, err_overflow=0, err_ack=0. With empty staging, s_ready=1 during and after reset.
- **Reset mid-burst:** staged words are discarded. No partial write is completed.

## Timing
- fifo_wr_en, fifo_din and burst_active are registered. burst_active equals fifo_wr_en except during full stalls, where burst_active stays high.
- **Burst latency:**
  - Final accept at edge k puts the FSM in WAIT_ROOM.
  - If room is available, edge k+1 enters DRAIN and presents word 0 with fifo_wr_en=1.
  - Word n is presented at edge k+1+n.
  - The FSM returns to IDLE at edge k+1+stage_cnt, and s_ready is high in that cycle.
- **Flush timing:** a timeout flush enters WAIT_ROOM on the edge where idle_cnt reaches FLUSH_TIMEOUT.

## Configuration
- **ACK_CHECK_EN defined:** a 1-bit expected-ack register is loaded with fifo_wr_en each cycle. err_ack is set when fifo_wr_ack differs from that register.
- **ACK_CHECK_EN undefined:** err_ack is tied to 0 and fifo_wr_ack is ignored.

## Structure
- **Package fifo_writer_pkg:** holds the typedef enum logic [1:0] wr_state_t {IDLE, FILL, WAIT_ROOM, DRAIN}.
- **Sub-module fifo_wr_stage:** the staging register array, with write index, read index and count. Its parameters are DATA_WIDTH and BURST_LEN. The FSM lives in fifo_burst_writer.

## Test plan
- **Full burst:** 4 back-to-back words 0x11,0x22,0x33,0x44 with fifo_wr_count=0. Expect fifo_wr_en high for exactly 4 cycles starting 1 cycle after the last accept, the same data in order, and bursts_done=1.
- **s_last flush:** 2 words 0xA0,0xA1 with s_last on 0xA1. Expect a 2-word burst with no wait for timeout, and s_ready low from the s_last accept until the FSM returns to IDLE.
- **Timeout flush:** one word 0x5A, then s_valid low. Expect WAIT_ROOM after 15 idle cycles, then a single write of 0x5A.
- **Room gating:** fifo_wr_count=13 with 4 words staged. Expect no writes. Drop fifo_wr_count to 12 and expect the burst to start on the next edge.
- **Full during DRAIN:** force fifo_full for 1 cycle at word 2. Expect fifo_wr_en low for that cycle, words resumed without loss, and err_overflow=1 sticky.
- **Reset and ack check:** assert rst_n=0 at word 1 of DRAIN. Expect all outputs at reset values and nothing further written. With ACK_CHECK_EN, withhold one fifo_wr_ack and expect err_ack=1.

Source files
------------

// File: rtl/fifo_writer_pkg.sv
// rtl/fifo_writer_pkg.sv - shared types for the FIFO burst writer
package fifo_writer_pkg;
  typedef enum logic [1:0] {IDLE, FILL, WAIT_ROOM, DRAIN} wr_state_t;
endpackage

// File: rtl/fifo_wr_stage.sv
// rtl/fifo_wr_stage.sv - staging register array feeding one FIFO burst
module fifo_wr_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  localparam int CNTW = $clog2(BURST_LEN + 1),
  localparam int IW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic                  wr_clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [CNTW-1:0]       count,
  output logic [CNTW-1:0]       rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [0:(1<<IW)-1];
  logic [CNTW-1:0]       wr_idx;

  // Words are only appended after a clear, so the write index doubles as the count.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx <= '0;
      rd_idx <= '0;
    end else if (clr) begin
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + 1'b1;
      if (pop)  rd_idx <= rd_idx + 1'b1;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (push) mem[wr_idx[IW-1:0]] <= push_data;
  end

  assign count   = wr_idx;
  assign rd_data = mem[rd_idx[IW-1:0]];
endmodule

// File: rtl/fifo_burst_writer.sv
// rtl/fifo_burst_writer.sv - stages words and writes whole bursts into the async FIFO
// Optional ACK_CHECK_EN: checks fifo_wr_ack against the previous cycle's fifo_wr_en.
module fifo_burst_writer
  import fifo_writer_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int BURST_LEN     = 4,
  parameter int FLUSH_TIMEOUT = 15,
  localparam int CW = $clog2(FIFO_DEPTH - 1) + 1
) (
  input  logic                  wr_clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_din,
  input  logic                  fifo_full,
  input  logic [CW-1:0]         fifo_wr_count,
  input  logic                  fifo_wr_ack,
  output logic                  burst_active,
  output logic [15:0]           bursts_done,
  output logic                  err_overflow,
  output logic                  err_ack
);
  localparam int CNTW = $clog2(BURST_LEN + 1);
  localparam int TW   = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
  localparam logic [CNTW-1:0] BURST_C      = CNTW'(BURST_LEN);
  localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(FLUSH_TIMEOUT - 1);
  localparam logic [CW:0]     DEPTH_C      = (CW + 1)'(FIFO_DEPTH);

  wr_state_t             state, next_state;
  logic [CNTW-1:0]       stage_cnt, rd_idx;
  logic [DATA_WIDTH-1:0] rd_data, din_d;
  logic [TW-1:0]         idle_cnt;
  logic [CW:0]           room;
  logic                  last_seen, accept, room_ok, fill_done, timeout_hit, drain_done;
  logic                  pop, clr, wr_en_d, burst_active_d;

  fifo_wr_stage #(.DATA_WIDTH(DATA_WIDTH), .BURST_LEN(BURST_LEN)) u_stage (
    .wr_clk    (wr_clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .push      (accept),
    .push_data (s_data),
    .pop       (pop),
    .count     (stage_cnt),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data)
  );

  assign s_ready     = (state == IDLE || state == FILL) && stage_cnt < BURST_C && !last_seen;
  assign accept      = s_valid && s_ready;
  assign fill_done   = accept && (s_last || stage_cnt + 1'b1 == BURST_C);
  assign timeout_hit = (FLUSH_TIMEOUT != 0) && state == FILL && !accept && idle_cnt == TIMEOUT_LAST;
  // Occupancy is pessimistic, so this room figure can only under-estimate.
  assign room        = DEPTH_C - {1'b0, fifo_wr_count};
  assign room_ok     = room >= (CW + 1)'(stage_cnt) && !fifo_full;
  assign drain_done  = state == DRAIN && !fifo_full && fifo_wr_en && rd_idx == stage_cnt;

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, FILL: begin
        if (fill_done || timeout_hit) next_state = WAIT_ROOM;
        else if (accept)              next_state = FILL;
      end
      WAIT_ROOM: if (room_ok)    next_state = DRAIN;
      DRAIN:     if (drain_done) next_state = IDLE;
      default:                   next_state = IDLE;
    endcase
  end

  // A word presented while full is not consumed: it stays in fifo_din and is re-presented.
  always_comb begin
    pop            = 1'b0;
    clr            = 1'b0;
    wr_en_d        = 1'b0;
    din_d          = fifo_din;
    burst_active_d = (next_state == DRAIN);
    case (state)
      WAIT_ROOM: begin
        if (room_ok) begin
          wr_en_d = 1'b1;
          din_d   = rd_data;
          pop     = 1'b1;
        end
      end
      DRAIN: begin
        if (fifo_full) begin
          wr_en_d = 1'b0;
        end else if (drain_done) begin
          clr = 1'b1;
        end else begin
          wr_en_d = 1'b1;
          if (fifo_wr_en) begin
            din_d = rd_data;
            pop   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_en   <= 1'b0;
      fifo_din     <= '0;
      burst_active <= 1'b0;
      bursts_done  <= '0;
      err_overflow <= 1'b0;
      idle_cnt     <= '0;
      last_seen    <= 1'b0;
    end else begin
      fifo_wr_en   <= wr_en_d;
      fifo_din     <= din_d;
      burst_active <= burst_active_d;
      idle_cnt     <= (state == FILL && !accept) ? idle_cnt + 1'b1 : '0;
      if (clr)                      bursts_done  <= bursts_done + 16'd1;
      if (state == DRAIN && fifo_full) err_overflow <= 1'b1;
      if (accept && s_last)         last_seen    <= 1'b1;
      else if (clr)                 last_seen    <= 1'b0;
    end
  end

`ifdef ACK_CHECK_EN
  logic ack_exp, err_ack_q;
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_exp   <= 1'b0;
      err_ack_q <= 1'b0;
    end else begin
      ack_exp <= fifo_wr_en;
      if (fifo_wr_ack != ack_exp) err_ack_q <= 1'b1;
    end
  end
  assign err_ack = err_ack_q;
`else
  logic unused_wr_ack;
  assign unused_wr_ack = fifo_wr_ack;
  assign err_ack       = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_burst_writer.sv
// tb/tb_fifo_burst_writer.sv - directed and randomized bench for fifo_burst_writer
// Expected err_ack follows ACK_CHECK_EN when the bench is built with it.
module tb_fifo_burst_writer;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int BL = 4;
  localparam int TO = 15;
  localparam int CW = $clog2(DEPTH - 1) + 1;

  logic          wr_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [DW-1:0] s_data = '0, fifo_din;
  logic          fifo_wr_en, fifo_full = 1'b0, fifo_wr_ack = 1'b0;
  logic [CW-1:0] fifo_wr_count = '0;
  logic          burst_active, err_overflow, err_ack;
  logic [15:0]   bursts_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 wr_clk = ~wr_clk;

  fifo_burst_writer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .BURST_LEN(BL), .FLUSH_TIMEOUT(TO)) dut (
    .wr_clk        (wr_clk),
    .rst_n         (rst_n),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_last        (s_last),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_din      (fifo_din),
    .fifo_full     (fifo_full),
    .fifo_wr_count (fifo_wr_count),
    .fifo_wr_ack   (fifo_wr_ack),
    .burst_active  (burst_active),
    .bursts_done   (bursts_done),
    .err_overflow  (err_overflow),
    .err_ack       (err_ack)
  );

  // FIFO-side model: records accepted words, burst lengths, and drives acks.
  logic [DW-1:0] got_q[$];
  int            len_q[$];
  int            cur_len = 0, writes = 0;
  bit            prev_active = 0, ack_next = 0, withhold = 0, ack_exp_m = 0, ack_err_m = 0;

  always @(negedge wr_clk) begin
    if (!rst_n) begin
      cur_len = 0; prev_active = 0; ack_next = 0; ack_exp_m = 0; ack_err_m = 0;
    end else begin
      if (fifo_wr_ack !== ack_exp_m) ack_err_m = 1;
      ack_exp_m = fifo_wr_en;
      ack_next = 0;
      if (fifo_wr_en && !fifo_full) begin
        got_q.push_back(fifo_din);
        writes++;
        cur_len++;
        if (withhold) withhold = 0;
        else ack_next = 1;
      end
      if (prev_active && !burst_active) begin
        len_q.push_back(cur_len);
        cur_len = 0;
      end
      prev_active = burst_active;
    end
  end

  always @(posedge wr_clk) begin
    #1 fifo_wr_ack = ack_next;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_err_ack();
`ifdef ACK_CHECK_EN
    return ack_err_m;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input bit last, input int gap);
    int budget = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    @(negedge wr_clk);
    while (!s_ready && budget < 200) begin
      @(negedge wr_clk);
      budget++;
    end
    if (budget >= 200) check_eq("send_ready", s_ready, 1);
    step();
    s_valid = 1'b0; s_last = 1'b0;
    repeat (gap) step();
  endtask

  // Called one step after the edge that enters WAIT_ROOM with room available.
  task automatic expect_burst(input string tag, input logic [DW-1:0] w[$]);
    @(negedge wr_clk);
    check_eq({tag, "_wait_en"}, fifo_wr_en, 0);
    check_eq({tag, "_wait_rdy"}, s_ready, 0);
    foreach (w[i]) begin
      @(negedge wr_clk);
      check_eq({tag, "_en"}, fifo_wr_en, 1);
      check_eq({tag, "_din"}, fifo_din, w[i]);
      check_eq({tag, "_rdy"}, s_ready, 0);
      check_eq({tag, "_active"}, burst_active, 1);
    end
    @(negedge wr_clk);
    check_eq({tag, "_end_en"}, fifo_wr_en, 0);
    check_eq({tag, "_end_rdy"}, s_ready, 1);
    check_eq({tag, "_end_active"}, burst_active, 0);
    step();
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_rdy"}, s_ready, 1);
    check_eq({tag, "_en"}, fifo_wr_en, 0);
    check_eq({tag, "_din"}, fifo_din, 0);
    check_eq({tag, "_active"}, burst_active, 0);
    check_eq({tag, "_bursts"}, bursts_done, 0);
    check_eq({tag, "_ovf"}, err_overflow, 0);
    check_eq({tag, "_ack"}, err_ack, 0);
  endtask

  initial begin
    logic [DW-1:0] wq[$];
    logic [DW-1:0] rd[$];
    bit            rl[$];
    int            rg[$];
    int            exp_lens[$];
    int            exp_bursts, cnt, budget, w0, act;

    repeat (3) @(negedge wr_clk);
    check_reset_values("in_reset");
    step();
    rst_n = 1'b1;
    step();
    exp_bursts = 0;

    wq = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (wq[i]) send_word(wq[i], 0, 0);
    expect_burst("full", wq);
    exp_bursts++;
    check_eq("full_bursts", bursts_done, exp_bursts);

    wq = '{8'hA0, 8'hA1};
    send_word(wq[0], 0, 0);
    send_word(wq[1], 1, 0);
    expect_burst("last", wq);
    exp_bursts++;
    check_eq("last_bursts", bursts_done, exp_bursts);

    wq = '{8'h5A};
    send_word(wq[0], 0, 0);
    repeat (TO - 1) step();
    @(negedge wr_clk);
    check_eq("tmo_still_fill", s_ready, 1);
    check_eq("tmo_no_write", fifo_wr_en, 0);
    step();
    expect_burst("tmo", wq);
    exp_bursts++;
    check_eq("tmo_bursts", bursts_done, exp_bursts);

    fifo_wr_count = CW'(13);
    wq = '{8'(32'($urandom)), 8'(32'($urandom)), 8'(32'($urandom)), 8'(32'($urandom))};
    foreach (wq[i]) send_word(wq[i], 0, 0);
    act = 0;
    repeat (5) begin
      @(negedge wr_clk);
      if (fifo_wr_en || burst_active) act++;
    end
    check_eq("room_blocked", act, 0);
    step();
    fifo_wr_count = CW'(12);
    expect_burst("room", wq);
    fifo_wr_count = '0;
    exp_bursts++;
    check_eq("room_bursts", bursts_done, exp_bursts);

    // Random packets: groups close on BURST_LEN words, s_last, or a long idle gap.
    got_q.delete(); len_q.delete();
    for (int i = 0; i < 40; i++) begin
      rd.push_back(8'(32'($urandom)));
      rl.push_back(i == 39 || $urandom_range(0, 4) == 0);
      rg.push_back(($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3)));
    end
    cnt = 0;
    foreach (rd[i]) begin
      cnt++;
      if (cnt == BL || rl[i] || rg[i] >= 20) begin
        exp_lens.push_back(cnt);
        cnt = 0;
      end
    end
    foreach (rd[i]) send_word(rd[i], rl[i], rg[i]);
    budget = 0;
    @(negedge wr_clk);
    while (!(s_ready && !burst_active) && budget < 100) begin
      @(negedge wr_clk);
      budget++;
    end
    check_eq("rnd_settled", s_ready && !burst_active, 1);
    step();
    check_eq("rnd_nwords", got_q.size(), rd.size());
    for (int i = 0; i < rd.size() && i < got_q.size(); i++) check_eq("rnd_word", got_q[i], rd[i]);
    check_eq("rnd_nbursts", len_q.size(), exp_lens.size());
    for (int i = 0; i < exp_lens.size() && i < len_q.size(); i++) check_eq("rnd_len", len_q[i], exp_lens[i]);
    exp_bursts += exp_lens.size();
    check_eq("rnd_bursts", bursts_done, exp_bursts);
    check_eq("rnd_ovf", err_overflow, 0);
    check_eq("rnd_ack", err_ack, exp_err_ack());

    withhold = 1;
    wq = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    foreach (wq[i]) send_word(wq[i], 0, 0);
    expect_burst("ackw", wq);
    repeat (2) step();
    exp_bursts++;
`ifdef ACK_CHECK_EN
    check_eq("ackw_model", ack_err_m, 1);
`endif
    check_eq("ackw_err", err_ack, exp_err_ack());

    got_q.delete();
    wq = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    foreach (wq[i]) send_word(wq[i], 0, 0);
    @(negedge wr_clk); check_eq("ovf_wait", fifo_wr_en, 0);
    @(negedge wr_clk); check_eq("ovf_w0", fifo_din, wq[0]);
    @(negedge wr_clk); check_eq("ovf_w1", fifo_din, wq[1]);
    step();
    fifo_full = 1'b1;
    @(negedge wr_clk);
    check_eq("ovf_w2_en", fifo_wr_en, 1);
    check_eq("ovf_pre", err_overflow, 0);
    step();
    fifo_full = 1'b0;
    @(negedge wr_clk);
    check_eq("ovf_stall_en", fifo_wr_en, 0);
    check_eq("ovf_stall_active", burst_active, 1);
    check_eq("ovf_set", err_overflow, 1);
    @(negedge wr_clk); check_eq("ovf_w2_again", fifo_din, wq[2]); check_eq("ovf_w2_en2", fifo_wr_en, 1);
    @(negedge wr_clk); check_eq("ovf_w3", fifo_din, wq[3]); check_eq("ovf_w3_en", fifo_wr_en, 1);
    @(negedge wr_clk); check_eq("ovf_end_en", fifo_wr_en, 0); check_eq("ovf_end_rdy", s_ready, 1);
    step();
    exp_bursts++;
    check_eq("ovf_nwords", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) check_eq("ovf_word", got_q[i], wq[i]);
    check_eq("ovf_sticky", err_overflow, 1);
    check_eq("ovf_bursts", bursts_done, exp_bursts);
    check_eq("ovf_ack", err_ack, exp_err_ack());

    wq = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
    foreach (wq[i]) send_word(wq[i], 0, 0);
    @(negedge wr_clk);
    @(negedge wr_clk); check_eq("rst_w0", fifo_din, wq[0]);
    step();
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    repeat (3) step();
    rst_n = 1'b1;
    w0 = writes;
    act = 0;
    repeat (20) begin
      @(negedge wr_clk);
      if (burst_active || fifo_wr_en) act++;
    end
    step();
    check_eq("rst_no_active", act, 0);
    check_eq("rst_no_write", writes - w0, 0);

    wq = '{8'hE0, 8'hE1};
    send_word(wq[0], 0, 0);
    send_word(wq[1], 1, 0);
    expect_burst("post_rst", wq);
    check_eq("post_rst_bursts", bursts_done, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
